exec_iter_unit: RTL and testbench

- Execute-stage consumer of the operand-select outputs: alu_op1/alu_op2 (ALU operands) and npc_op1/npc_op2 (next-PC operands), plus alu_code and pc.
- Produces the writeback result, the resolved next PC and a branch-taken flag.
- Uses a valid/ready handshake on both sides.
- Single-cycle ops complete in 1 cycle; shifts run 1 bit per cycle; optional iterative multiply.
- Sits between the operand switcher and writeback/fetch redirect.

---
 rtl/exec_iter_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_exec_iter_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_iter_unit.sv
// exec_iter_unit: execute stage behind the operand switcher.
// It computes the writeback result, the resolved next PC and a branch-taken
// flag. Most ops take one cycle. Shifts step one bit per cycle.
// Optional iterative multiply is built only when EXEC_ITER_MUL_EN is defined.
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE.
// While out_valid && !out_ready, all outputs hold.
// Leaving DONE takes one cycle, so no accept happens in that cycle.
module exec_iter_unit #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      alu_code,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_op1,
  input  logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] npc_op1,
  input  logic [XLEN-1:0] npc_op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] next_pc,
  output logic            branch_taken,
  output logic            illegal
);
  localparam logic [6:0] ALU_ADD  = 7'h01, ALU_SUB  = 7'h02, ALU_AND  = 7'h03;
  localparam logic [6:0] ALU_OR   = 7'h04, ALU_XOR  = 7'h05, ALU_SLT  = 7'h06;
  localparam logic [6:0] ALU_SLTU = 7'h07, ALU_LUI  = 7'h08, ALU_SLL  = 7'h09;
  localparam logic [6:0] ALU_SRL  = 7'h0A, ALU_SRA  = 7'h0B, ALU_JAL  = 7'h0C;
  localparam logic [6:0] ALU_JALR = 7'h0D, ALU_BEQ  = 7'h10, ALU_BNE  = 7'h11;
  localparam logic [6:0] ALU_BLT  = 7'h12, ALU_BGE  = 7'h13, ALU_BLTU = 7'h14;
  localparam logic [6:0] ALU_BGEU = 7'h15;
`ifdef EXEC_ITER_MUL_EN
  localparam logic [6:0] ALU_MUL  = 7'h20;
`endif
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

`ifdef EXEC_ITER_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t state, next_state;

  logic            accept;
  logic [XLEN-1:0] npc_sum, pc_fall;
  logic [XLEN-1:0] dec_res, dec_npc;
  logic            dec_taken, dec_illegal, dec_shift, dec_mul, is_br, br_cond;
  logic [1:0]      dec_kind;
  logic [SW-1:0]   shamt;

  logic [XLEN-1:0] acc, shift_next;
  logic [CW-1:0]   cnt;
  logic [1:0]      kind;
`ifdef EXEC_ITER_MUL_EN
  logic [XLEN-1:0] mcand, mplier, mul_next;
`endif

  assign accept  = in_valid && in_ready;
  assign npc_sum = npc_op1 + npc_op2;
  assign pc_fall = pc + XLEN'(PC_STEP);
  assign shamt   = alu_op2[SW-1:0];

  // Decode the presented operation into its one-cycle outcome and path choice
  always_comb begin
    dec_res     = '0;
    dec_npc     = npc_sum;
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    dec_shift   = 1'b0;
    dec_mul     = 1'b0;
    dec_kind    = 2'd0;
    is_br       = 1'b0;
    br_cond     = 1'b0;
    case (alu_code)
      ALU_ADD:  dec_res = alu_op1 + alu_op2;
      ALU_SUB:  dec_res = alu_op1 - alu_op2;
      ALU_AND:  dec_res = alu_op1 & alu_op2;
      ALU_OR:   dec_res = alu_op1 | alu_op2;
      ALU_XOR:  dec_res = alu_op1 ^ alu_op2;
      ALU_SLT:  dec_res = {{(XLEN-1){1'b0}}, $signed(alu_op1) < $signed(alu_op2)};
      ALU_SLTU: dec_res = {{(XLEN-1){1'b0}}, alu_op1 < alu_op2};
      ALU_LUI:  dec_res = alu_op2;
      ALU_SLL:  begin dec_shift = 1'b1; dec_kind = 2'd0; dec_res = alu_op1; end
      ALU_SRL:  begin dec_shift = 1'b1; dec_kind = 2'd1; dec_res = alu_op1; end
      ALU_SRA:  begin dec_shift = 1'b1; dec_kind = 2'd2; dec_res = alu_op1; end
      ALU_JAL:  begin dec_res = alu_op2 + XLEN'(PC_STEP); dec_taken = 1'b1; end
      ALU_JALR: begin
        dec_res   = alu_op2 + XLEN'(PC_STEP);
        dec_npc   = npc_sum & ~XLEN'(1);
        dec_taken = 1'b1;
      end
      ALU_BEQ:  begin is_br = 1'b1; br_cond = (alu_op1 == alu_op2); end
      ALU_BNE:  begin is_br = 1'b1; br_cond = (alu_op1 != alu_op2); end
      ALU_BLT:  begin is_br = 1'b1; br_cond = ($signed(alu_op1) < $signed(alu_op2)); end
      ALU_BGE:  begin is_br = 1'b1; br_cond = ($signed(alu_op1) >= $signed(alu_op2)); end
      ALU_BLTU: begin is_br = 1'b1; br_cond = (alu_op1 < alu_op2); end
      ALU_BGEU: begin is_br = 1'b1; br_cond = (alu_op1 >= alu_op2); end
`ifdef EXEC_ITER_MUL_EN
      ALU_MUL:  dec_mul = 1'b1;
`endif
      default: begin
        dec_illegal = 1'b1;
        dec_npc     = pc_fall;
      end
    endcase
    if (is_br) begin
      dec_taken = br_cond;
      dec_npc   = br_cond ? npc_sum : pc_fall;
    end
  end

  // One-bit step of the latched shift
  always_comb begin
    case (kind)
      2'd1:    shift_next = {1'b0, acc[XLEN-1:1]};
      2'd2:    shift_next = {acc[XLEN-1], acc[XLEN-1:1]};
      default: shift_next = {acc[XLEN-2:0], 1'b0};
    endcase
  end

`ifdef EXEC_ITER_MUL_EN
  // Shift-add partial product: add the multiplicand when the multiplier LSB is set
  always_comb begin
    mul_next = acc + (mplier[0] ? mcand : '0);
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: a shift of zero and all plain ops go straight to DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_shift && (shamt != '0)) next_state = SHIFT;
`ifdef EXEC_ITER_MUL_EN
          else if (dec_mul)               next_state = MUL;
`endif
          else                            next_state = DONE;
        end
      end
      SHIFT: if (cnt == CW'(1)) next_state = DONE;
`ifdef EXEC_ITER_MUL_EN
      MUL:   if (cnt == CW'(1)) next_state = DONE;
`endif
      DONE:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: latch everything at accept, then iterate; outputs hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      next_pc      <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      kind         <= 2'd0;
`ifdef EXEC_ITER_MUL_EN
      mcand        <= '0;
      mplier       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            result       <= dec_res;
            next_pc      <= dec_npc;
            branch_taken <= dec_taken;
            illegal      <= dec_illegal;
            kind         <= dec_kind;
            acc          <= alu_op1;
            cnt          <= CW'(shamt);
`ifdef EXEC_ITER_MUL_EN
            if (dec_mul) begin
              acc    <= '0;
              cnt    <= CW'(XLEN);
              mcand  <= alu_op1;
              mplier <= alu_op2;
            end
`endif
          end
        end
        SHIFT: begin
          acc <= shift_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) result <= shift_next;
        end
`ifdef EXEC_ITER_MUL_EN
        MUL: begin
          acc    <= mul_next;
          mcand  <= {mcand[XLEN-2:0], 1'b0};
          mplier <= {1'b0, mplier[XLEN-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) result <= mul_next;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_iter_unit.sv
// Bench for exec_iter_unit: table vectors, hand sequences for reset and
// backpressure, then random ops checked against a behavioural model.
module tb_exec_iter_unit;
  localparam logic [6:0] ADD = 7'h01, SUB = 7'h02, AND_ = 7'h03, OR_ = 7'h04;
  localparam logic [6:0] XOR_ = 7'h05, SLT = 7'h06, SLTU = 7'h07, LUI = 7'h08;
  localparam logic [6:0] SLL = 7'h09, SRL = 7'h0A, SRA = 7'h0B, JAL = 7'h0C;
  localparam logic [6:0] JALR = 7'h0D, BEQ = 7'h10, BNE = 7'h11, BLT = 7'h12;
  localparam logic [6:0] BGE = 7'h13, BLTU = 7'h14, BGEU = 7'h15, MUL = 7'h20;

  typedef struct {
    logic [6:0]  code;
    logic [31:0] pc, op1, op2, n1, n2;
    logic [31:0] res, npc;
    logic        tk, ill;
    int          lat;
    int          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  alu_code;
  logic [31:0] pc, alu_op1, alu_op2, npc_op1, npc_op2, result, next_pc;
  logic        branch_taken, illegal;

  int total = 0;
  int bad   = 0;
  logic [65:0] exp_q[$];
  vec_t vecs[15];
  logic [6:0] codes[20];

  always #5 clk = ~clk;

  exec_iter_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_code(alu_code), .pc(pc), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .npc_op1(npc_op1), .npc_op2(npc_op2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .next_pc(next_pc),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] code, input logic [31:0] p, a, b, n1, n2,
                              input logic [31:0] res, npc, input logic tk, ill,
                              input int lat, hold);
    vec_t v;
    v.code = code; v.pc = p; v.op1 = a; v.op2 = b; v.n1 = n1; v.n2 = n2;
    v.res = res; v.npc = npc; v.tk = tk; v.ill = ill; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Behavioural reference: what an instruction should produce, from the ISA rules
  function automatic vec_t ref_model(input logic [6:0] code, input logic [31:0] p, a, b, n1, n2);
    vec_t v;
    logic c;
    v = mk(code, p, a, b, n1, n2, 32'd0, n1 + n2, 1'b0, 1'b0, 1, 0);
    c = 1'b0;
    case (code)
      ADD:  v.res = a + b;
      SUB:  v.res = a - b;
      AND_: v.res = a & b;
      OR_:  v.res = a | b;
      XOR_: v.res = a ^ b;
      SLT:  v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: v.res = (a < b) ? 32'd1 : 32'd0;
      LUI:  v.res = b;
      SLL:  begin v.res = a << b[4:0]; v.lat = 1 + int'(b[4:0]); end
      SRL:  begin v.res = a >> b[4:0]; v.lat = 1 + int'(b[4:0]); end
      SRA:  begin v.res = $unsigned($signed(a) >>> b[4:0]); v.lat = 1 + int'(b[4:0]); end
      JAL:  begin v.res = b + 32'd4; v.tk = 1'b1; end
      JALR: begin v.res = b + 32'd4; v.npc = (n1 + n2) & 32'hFFFF_FFFE; v.tk = 1'b1; end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        case (code)
          BEQ:     c = (a == b);
          BNE:     c = (a != b);
          BLT:     c = ($signed(a) < $signed(b));
          BGE:     c = ($signed(a) >= $signed(b));
          BLTU:    c = (a < b);
          default: c = (a >= b);
        endcase
        v.tk  = c;
        v.npc = c ? (n1 + n2) : (p + 32'd4);
      end
`ifdef EXEC_ITER_MUL_EN
      MUL:  begin v.res = a * b; v.lat = 33; end
`endif
      default: begin v.ill = 1'b1; v.npc = p + 32'd4; end
    endcase
    return v;
  endfunction

  // Drive one operation, wait for its result, compare, apply optional backpressure
  task automatic run_op(input vec_t v);
    int guard, lat;
    logic [65:0] e;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    out_ready = (v.hold == 0);
    alu_code = v.code; pc = v.pc; alu_op1 = v.op1; alu_op2 = v.op2;
    npc_op1 = v.n1; npc_op2 = v.n2; in_valid = 1'b1;
    exp_q.push_back({v.res, v.npc, v.tk, v.ill});
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_code = 7'($urandom); pc = $urandom; alu_op1 = $urandom; alu_op2 = $urandom;
    npc_op1 = $urandom; npc_op2 = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && v.lat > 1) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    end while (!out_valid && lat < 100);
    check("latency", 32'(lat), 32'(v.lat));
    e = exp_q.pop_front();
    check("result", result, e[65:34]);
    check("next_pc", next_pc, e[33:2]);
    check("taken", {31'd0, branch_taken}, {31'd0, e[1]});
    check("illegal", {31'd0, illegal}, {31'd0, e[0]});
    if (v.hold > 0) begin
      for (int i = 1; i < v.hold; i++) begin
        @(negedge clk);
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_result", result, e[65:34]);
        check("hold_next_pc", next_pc, e[33:2]);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", {31'd0, in_ready}, 32'd1);
      check("release_out_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    int guard, seen;
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_code = '0; pc = '0; alu_op1 = '0; alu_op2 = '0; npc_op1 = '0; npc_op2 = '0;

    vecs[0]  = mk(ADD,  32'd10, 32'd5, 32'd9, 32'd10, 32'd4, 32'd14, 32'd14, 0, 0, 1, 0);
    vecs[1]  = mk(BEQ,  32'd2, 32'd3, 32'd3, 32'd2, 32'd7, 32'd0, 32'd9, 1, 0, 1, 0);
    vecs[2]  = mk(BEQ,  32'd2, 32'd3, 32'd4, 32'd2, 32'd7, 32'd0, 32'd6, 0, 0, 1, 0);
    vecs[3]  = mk(JALR, 32'd1, 32'd0, 32'd1, 32'd2, 32'd7, 32'd5, 32'd8, 1, 0, 1, 0);
    vecs[4]  = mk(SRA,  32'd0, 32'h8000_0000, 32'd4, 32'h100, 32'h20, 32'hF800_0000, 32'h120, 0, 0, 5, 3);
    vecs[5]  = mk(SLL,  32'd0, 32'h1234, 32'd0, 32'h10, 32'h8, 32'h1234, 32'h18, 0, 0, 1, 0);
    vecs[6]  = mk(7'h7F, 32'h40, 32'd1, 32'd2, 32'h500, 32'h4, 32'd0, 32'h44, 0, 1, 1, 0);
    vecs[7]  = mk(SUB,  32'd0, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'd8, 32'hFFFF_FFFF, 32'd4, 0, 0, 1, 0);
    vecs[8]  = mk(SLT,  32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 0, 0, 1, 0);
    vecs[9]  = mk(SLTU, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0);
    vecs[10] = mk(BLT,  32'h80, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h10, 32'd0, 32'h90, 1, 0, 1, 0);
    vecs[11] = mk(BLTU, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h10, 32'd0, 32'h84, 0, 0, 1, 0);
    vecs[12] = mk(JAL,  32'h100, 32'd0, 32'h100, 32'h100, 32'hFFFF_FFF0, 32'h104, 32'hF0, 1, 0, 1, 0);
    vecs[13] = mk(SRL,  32'd0, 32'h8000_0000, 32'd31, 32'd1, 32'd2, 32'd1, 32'd3, 0, 0, 32, 0);
`ifdef EXEC_ITER_MUL_EN
    vecs[14] = mk(MUL,  32'h20, 32'hFFFF_FFFF, 32'd3, 32'h20, 32'h4, 32'hFFFF_FFFD, 32'h24, 0, 0, 33, 0);
`else
    vecs[14] = mk(MUL,  32'h20, 32'hFFFF_FFFF, 32'd3, 32'h20, 32'h4, 32'd0, 32'h24, 0, 1, 1, 0);
`endif
    codes = '{ADD, SUB, AND_, OR_, XOR_, SLT, SLTU, LUI, SLL, SRL,
              SRA, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, MUL};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_next_pc", next_pc, 32'd0);
    check("rst_flags", {30'd0, branch_taken, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 15; i++) run_op(vecs[i]);

    // Reset in the middle of a long shift aborts it silently
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    alu_code = SLL; pc = 32'h10; alu_op1 = 32'hDEAD_BEEF; alu_op2 = 32'd31;
    npc_op1 = 32'h3; npc_op2 = 32'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_shift_busy", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_next_pc", next_pc, 32'd0);
    check("abort_flags", {30'd0, branch_taken, illegal}, 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    check("abort_no_emit", 32'(seen), 32'd0);

    // Random ops against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [6:0] c;
      c = ($urandom_range(0, 9) == 0) ? 7'($urandom) : codes[$urandom_range(0, 19)];
      v = ref_model(c, $urandom, $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) v.hold = $urandom_range(1, 3);
      run_op(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Last-resort guard against a bench that stops making progress
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
